// File: rtl/mul_iter_32.sv
// mul_iter_32: iterative RV32M multiply unit (MUL/MULH/MULHSU/MULHU), one byte of |b| per CALC cycle
// Ports: clk_i clock; reset_i async active-high reset; start_i request (sampled when idle);
//   op_i 00 MUL / 01 MULH / 10 MULHSU / 11 MULHU; a_i, b_i operands; kill_i abort;
//   busy_o state != IDLE; done_o one-cycle result-valid pulse; result_o held until next done_o.
// Optional: define MUL_EARLY_EXIT_EN to leave CALC once the remaining bytes of |b| are zero.

// wallace_8: combinational 8x8 unsigned multiplier, carry-save reduction of partial products
// Ports: a, b 8-bit operands; p 16-bit product.
module wallace_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] pp [8];
    logic [15:0] s1a, c1a, s1b, c1b, s2a, c2a, s2b, c2b, s3, c3, s4, c4;

    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [15:0] c;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, x ^ y ^ z};
    endfunction

    always_comb
        for (int i = 0; i < 8; i++)
            pp[i] = b[i] ? 16'(a) << i : '0;

    // Carry-save sums stay exact modulo 2^16, and the product always fits in 16 bits.
    assign {c1a, s1a} = csa(pp[0], pp[1], pp[2]);
    assign {c1b, s1b} = csa(pp[3], pp[4], pp[5]);
    assign {c2a, s2a} = csa(s1a, c1a, s1b);
    assign {c2b, s2b} = csa(c1b, pp[6], pp[7]);
    assign {c3, s3}   = csa(s2a, c2a, s2b);
    assign {c4, s4}   = csa(s3, c3, c2b);
    assign p = s4 + c4;
endmodule

module mul_iter_32 #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int N  = XLEN / 8;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   ma, mb;
    logic [2*XLEN-1:0] acc, p;
    logic [XLEN+7:0]   row;
    logic [15:0]       prod [N];
    logic [7:0]        mb_byte;
    logic [1:0]        op;
    logic              neg, last, sa, sb, a_neg, b_neg;

    assign sa      = op_i == 2'b01 || op_i == 2'b10;
    assign sb      = op_i == 2'b01;
    assign a_neg   = sa && a_i[XLEN-1];
    assign b_neg   = sb && b_i[XLEN-1];
    assign mb_byte = 8'(mb >> (8 * cnt));
    assign busy_o  = state != IDLE;
    assign p       = neg ? -acc : acc;

    for (genvar j = 0; j < N; j++) begin : g_w
        wallace_8 u_w (.a(ma[8*j +: 8]), .b(mb_byte), .p(prod[j]));
    end

    always_comb begin
        row = '0;
        for (int j = 0; j < N; j++)
            row = row + ((XLEN+8)'(prod[j]) << (8 * j));
    end

`ifdef MUL_EARLY_EXIT_EN
    // Once no bits of |b| remain above byte cnt, acc already holds the full product.
    assign last = cnt == CW'(N - 1) || (mb >> (8 * (int'(cnt) + 1))) == '0;
`else
    assign last = cnt == CW'(N - 1);
`endif

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = kill_i ? IDLE :
                    state == IDLE ? (start_i ? CALC : IDLE) :
                    state == CALC ? (last ? FIX : CALC) : IDLE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt      <= '0;
            acc      <= '0;
            ma       <= '0;
            mb       <= '0;
            op       <= '0;
            neg      <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE && start_i && !kill_i) begin
                ma  <= a_neg ? -a_i : a_i;
                mb  <= b_neg ? -b_i : b_i;
                neg <= a_neg ^ b_neg;
                op  <= op_i;
                cnt <= '0;
                acc <= '0;
            end else if (state == CALC && !kill_i) begin
                acc <= acc + ((2*XLEN)'(row) << (8 * cnt));
                cnt <= cnt + CW'(1);
            end else if (state == FIX && !kill_i) begin
                result_o <= op == 2'b00 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
                done_o   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_iter_32.sv
// tb_mul_iter_32: self-checking bench for mul_iter_32 (vector table, corner sequences, random vs reference)
module tb_mul_iter_32;
    logic        clk = 1'b0;
    logic        reset_i, start_i, kill_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    mul_iter_32 dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .kill_i(kill_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: sign-extend per op to 64 bits and multiply.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be, pr;
        ae = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        be = (op == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        pr = ae * be;
        return op == 2'd0 ? pr[31:0] : pr[63:32];
    endfunction

    // Cycle (counted from the start-sampling edge) in which done_o is expected.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
        logic [31:0] mb;
        int nb;
        mb = (op == 2'd1 && b[31]) ? -b : b;
        nb = 1;
        for (int k = 1; k < 4; k++)
            if ((mb >> (8 * k)) != 0) nb = k + 1;
        return nb + 2;
`else
        return 6;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 255));
            4: return 32'h0000FFFF & $urandom;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit hold);
        int lat, el;
        bit busy_ok, busy_at_done;
        el = ref_lat(op, b);
        lat = 0;
        busy_ok = 1;
        busy_at_done = 1;
        @(negedge clk);
        start_i = 1; op_i = op; a_i = a; b_i = b;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c == (hold ? 4 : 1)) start_i = 0;
            if (done_o) begin
                lat = c;
                busy_at_done = busy_o;
            end else if (!busy_o) busy_ok = 0;
        end
        start_i = 0;
        check({name, "_latency"}, 32'(lat), 32'(el));
        check({name, "_result"}, result_o, exp);
        check({name, "_busy"}, {31'b0, busy_ok & ~busy_at_done}, 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, {30'b0, done_o, busy_o}, 32'd0);
    endtask

    initial begin
        bit seen;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        tbl[0] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[1] = '{2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        tbl[2] = '{2'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF};
        tbl[3] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        tbl[4] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[5] = '{2'd3, 32'h80000000, 32'h00000002, 32'h00000001};
        tbl[6] = '{2'd0, 32'h00000003, 32'h00000005, 32'h0000000F};
        tbl[7] = '{2'd3, 32'hFFFFFFFF, 32'h00000005, 32'h00000004};
        tbl[8] = '{2'd0, 32'h12345678, 32'h00000000, 32'h00000000};
        tbl[9] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

        reset_i = 1; start_i = 0; kill_i = 0; op_i = 0; a_i = 0; b_i = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy_o, done_o, result_o[29:0]}, 32'd0);
        check("reset_result", result_o, 32'd0);
        reset_i = 0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, 0);

        // Kill during CALC: no done, result keeps the previous value.
        run_op("pre_kill", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        @(negedge clk); start_i = 1; op_i = 0; a_i = 32'h12345678; b_i = 32'hFFFFFFFF;
        @(negedge clk); start_i = 0;
        @(negedge clk); kill_i = 1;
        @(negedge clk); kill_i = 0;
        check("kill_busy", {31'b0, busy_o}, 32'd0);
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= done_o; end
        check("kill_no_done", {31'b0, seen}, 32'd0);
        check("kill_result", result_o, 32'hFFFFFFFE);
        run_op("after_kill", 2'd0, 32'd3, 32'd5, 32'h0000000F, 0);

        // Kill together with start in IDLE drops the request.
        @(negedge clk); start_i = 1; kill_i = 1; op_i = 0; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk); start_i = 0; kill_i = 0;
        check("kill_start_busy", {31'b0, busy_o}, 32'd0);
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= done_o; end
        check("kill_start_no_done", {31'b0, seen}, 32'd0);
        check("kill_start_result", result_o, 32'h0000000F);

        // start_i held while busy is ignored; exactly one done.
        run_op("busy_start", 2'd0, 32'h01020304, 32'h01010101, ref_mul(2'd0, 32'h01020304, 32'h01010101), 1);
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= done_o | busy_o; end
        check("busy_start_single", {31'b0, seen}, 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk); start_i = 1; op_i = 2'd3; a_i = 32'hFFFFFFFF; b_i = 32'hFFFFFFFF;
        @(negedge clk); start_i = 0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1;
        #1;
        check("rst_mid_busy_done", {30'b0, busy_o, done_o}, 32'd0);
        check("rst_mid_result", result_o, 32'd0);
        @(negedge clk); reset_i = 0;
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= done_o | busy_o; end
        check("rst_mid_no_done", {31'b0, seen}, 32'd0);
        run_op("after_rst", 2'd1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 0);

        for (int i = 0; i < 2000; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), rop, ra, rb, ref_mul(rop, ra, rb), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
